// File: rtl/max_finder_pkg.sv
// Shared types and constants for the streaming maximum finder.
// The optional tie counter is enabled with MAX_FINDER_TIE_COUNT_EN.
package max_finder_pkg;

  localparam int SAMPLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/max_finder_comparator.sv
// Unsigned 4-bit magnitude comparator feeding the max_finder update path.
module four_bit_comparator
  import max_finder_pkg::*;
(
  input  logic [SAMPLE_W-1:0] x,
  input  logic [SAMPLE_W-1:0] y,
  output logic                o_gt,
  output logic                o_eq
);

  assign o_gt = (x > y);
  assign o_eq = (x == y);

endmodule

// File: rtl/max_finder.sv
// Streaming frame maximum finder: reports the max sample and its first index.
// Define MAX_FINDER_TIE_COUNT_EN to add the out_ties port and tie counter.
module max_finder
  import max_finder_pkg::*;
#(
  parameter  int FRAME_LEN = 8,
  localparam int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_max,
  output logic [IDX_W-1:0]    out_idx
`ifdef MAX_FINDER_TIE_COUNT_EN
  ,
  output logic [IDX_W-1:0]    out_ties
`endif
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

  state_t                state;
  logic [SAMPLE_W-1:0]   max_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      cnt_q;
  logic                  cmp_gt;
  logic                  xfer;

`ifdef MAX_FINDER_TIE_COUNT_EN
  logic                  cmp_eq;
  logic [IDX_W-1:0]      ties_q;
`endif

  four_bit_comparator u_cmp (
    .x    (in_data),
    .y    (max_q),
    .o_gt (cmp_gt),
`ifdef MAX_FINDER_TIE_COUNT_EN
    .o_eq (cmp_eq)
`else
    .o_eq ()
`endif
  );

  assign xfer    = in_valid && in_ready;
  assign out_max = max_q;
  assign out_idx = idx_q;
`ifdef MAX_FINDER_TIE_COUNT_EN
  assign out_ties = ties_q;
`endif

  // Only a strict greater-than replaces the max, so the first occurrence keeps its index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      max_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
`ifdef MAX_FINDER_TIE_COUNT_EN
      ties_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          if (xfer) begin
            if (cnt_q == '0) begin
              max_q  <= in_data;
              idx_q  <= '0;
`ifdef MAX_FINDER_TIE_COUNT_EN
              ties_q <= '0;
`endif
            end else if (cmp_gt) begin
              max_q  <= in_data;
              idx_q  <= cnt_q;
`ifdef MAX_FINDER_TIE_COUNT_EN
              ties_q <= '0;
            end else if (cmp_eq) begin
              if (ties_q != LAST) ties_q <= ties_q + 1'b1;
`endif
            end
            // The counter parks on the last index instead of wrapping.
            if (cnt_q == LAST) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_finder.sv
// Self-checking bench for max_finder at FRAME_LEN 8, 2 and 16.
// Build with MAX_FINDER_TIE_COUNT_EN defined to also check out_ties.
module tb_max_finder;

  typedef struct {
    int          sel;
    int          len;
    logic [63:0] samples;
    int          exp_max;
    int          exp_idx;
    int          exp_ties;
  } vec_t;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic [2:0]  start;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        out_ready;

  logic [2:0]  rdy;
  logic [2:0]  vld;
  logic [3:0]  max8, max2, max16;
  logic [2:0]  idx8;
  logic [0:0]  idx2;
  logic [3:0]  idx16;
`ifdef MAX_FINDER_TIE_COUNT_EN
  logic [2:0]  ties8;
  logic [0:0]  ties2;
  logic [3:0]  ties16;
`endif

  int checks = 0;
  int errors = 0;

  max_finder #(.FRAME_LEN(8)) dut8 (
    .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .out_valid(vld[0]), .out_ready(out_ready), .out_max(max8),
    .out_idx(idx8)
`ifdef MAX_FINDER_TIE_COUNT_EN
    , .out_ties(ties8)
`endif
  );

  max_finder #(.FRAME_LEN(2)) dut2 (
    .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .out_valid(vld[1]), .out_ready(out_ready), .out_max(max2),
    .out_idx(idx2)
`ifdef MAX_FINDER_TIE_COUNT_EN
    , .out_ties(ties2)
`endif
  );

  max_finder #(.FRAME_LEN(16)) dut16 (
    .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data), .out_valid(vld[2]), .out_ready(out_ready), .out_max(max16),
    .out_idx(idx16)
`ifdef MAX_FINDER_TIE_COUNT_EN
    , .out_ties(ties16)
`endif
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  function automatic int get_max(input int sel);
    return (sel == 0) ? int'(max8) : (sel == 1) ? int'(max2) : int'(max16);
  endfunction

  function automatic int get_idx(input int sel);
    return (sel == 0) ? int'(idx8) : (sel == 1) ? int'(idx2) : int'(idx16);
  endfunction

`ifdef MAX_FINDER_TIE_COUNT_EN
  function automatic int get_ties(input int sel);
    return (sel == 0) ? int'(ties8) : (sel == 1) ? int'(ties2) : int'(ties16);
  endfunction
`endif

  function automatic vec_t mkv(input int sel, input int len, input logic [63:0] s,
                               input int m, input int i, input int t);
    vec_t v;
    v.sel = sel; v.len = len; v.samples = s;
    v.exp_max = m; v.exp_idx = i; v.exp_ties = t;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Runs one unstalled frame with out_ready high; leaves the DUT in DONE.
  task automatic applyStimulus(input vec_t v);
    logic [63:0] s;
    s = v.samples;
    out_ready = 1'b1;
    start[v.sel] = 1'b1;
    step();
    start[v.sel] = 1'b0;
    for (int k = 0; k < v.len; k++) begin
      in_valid = 1'b1;
      in_data  = s[63-4*k -: 4];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput({tag, "_valid"}, int'(vld[v.sel]), 1);
    checkOutput({tag, "_max"}, get_max(v.sel), v.exp_max);
    checkOutput({tag, "_idx"}, get_idx(v.sel), v.exp_idx);
`ifdef MAX_FINDER_TIE_COUNT_EN
    checkOutput({tag, "_ties"}, get_ties(v.sel), v.exp_ties);
`endif
    step();
    checkOutput({tag, "_valid_drop"}, int'(vld[v.sel]), 0);
  endtask

  vec_t vecs[11];

  initial begin
    int rise;
    int high_cnt;
    logic [63:0] s;

    vecs[0]  = mkv(0, 8,  64'h1234_5678_0000_0000, 8,  7,  0);
    vecs[1]  = mkv(0, 8,  64'h3929_9014_0000_0000, 9,  1,  2);
    vecs[2]  = mkv(0, 8,  64'h0000_0000_0000_0000, 0,  0,  7);
    vecs[3]  = mkv(0, 8,  64'h8765_4321_0000_0000, 8,  0,  0);
    vecs[4]  = mkv(0, 8,  64'h0000_000F_0000_0000, 15, 7,  0);
    vecs[5]  = mkv(0, 8,  64'hFFFF_FFFF_0000_0000, 15, 0,  7);
    vecs[6]  = mkv(1, 2,  64'hFF00_0000_0000_0000, 15, 0,  1);
    vecs[7]  = mkv(1, 2,  64'h3A00_0000_0000_0000, 10, 1,  0);
    vecs[8]  = mkv(2, 16, 64'hFEDC_BA98_7654_3210, 15, 0,  0);
    vecs[9]  = mkv(2, 16, 64'h0123_4567_89AB_CDEF, 15, 15, 0);
    vecs[10] = mkv(2, 16, 64'h111F_1111_1111_F111, 15, 3,  1);

    clk_en = 1'b0; rst = 1'b0; start = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Async reset with the clock stopped.
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_in_ready", int'(rdy[0]), 0);
    checkOutput("rst_out_valid", int'(vld[0]), 0);
    checkOutput("rst_out_max", int'(max8), 0);
    checkOutput("rst_out_idx", int'(idx8), 0);
`ifdef MAX_FINDER_TIE_COUNT_EN
    checkOutput("rst_out_ties", int'(ties8), 0);
`endif
    clk_en = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Ascending frame timing: out_valid one cycle, on the 9th edge counting the start edge.
    out_ready = 1'b1;
    rise = 0;
    high_cnt = 0;
    for (int e = 1; e <= 14; e++) begin
      start[0] = (e == 1);
      in_valid = (e >= 2 && e <= 9);
      in_data  = 4'(e - 1);
      step();
      if (e == 1) checkOutput("asc_in_ready_rise", int'(rdy[0]), 1);
      if (vld[0]) begin
        high_cnt++;
        if (rise == 0) begin
          rise = e;
          checkOutput("asc_max", int'(max8), 8);
          checkOutput("asc_idx", int'(idx8), 7);
        end
      end
    end
    start[0] = 1'b0;
    in_valid = 1'b0;
    checkOutput("asc_valid_rise_edge", rise, 9);
    checkOutput("asc_valid_cycles", high_cnt, 1);
    checkOutput("asc_back_idle", int'(rdy[0]), 0);

    // Table-driven frames.
    for (int i = 0; i < 11; i++) runVec(vecs[i], $sformatf("v%0d", i));

    // Stalls, backpressure, and ignored start pulses.
    s = 64'h5F3F_07E1_0000_0000;
    out_ready = 1'b0;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    checkOutput("stall_in_ready", int'(rdy[0]), 1);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = s[63-4*k -: 4];
      step();
      in_valid = 1'b0;
      start[0] = (k == 2);
      step();
      start[0] = 1'b0;
      if (k < 7) checkOutput($sformatf("stall_run_valid%0d", k), int'(vld[0]), 0);
    end
    for (int j = 0; j < 4; j++) begin
      start[0] = (j == 1);
      checkOutput($sformatf("bp_valid%0d", j), int'(vld[0]), 1);
      checkOutput($sformatf("bp_max%0d", j), int'(max8), 15);
      checkOutput($sformatf("bp_idx%0d", j), int'(idx8), 1);
      checkOutput($sformatf("bp_in_ready%0d", j), int'(rdy[0]), 0);
      step();
    end
    start[0] = 1'b0;
`ifdef MAX_FINDER_TIE_COUNT_EN
    checkOutput("bp_ties", int'(ties8), 1);
`endif
    out_ready = 1'b1;
    step();
    checkOutput("bp_valid_drop", int'(vld[0]), 0);
    step();
    checkOutput("no_queued_start", int'(rdy[0]), 0);

    // Reset mid-frame, then a clean all-zero frame.
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 4'h9;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("abort_in_ready", int'(rdy[0]), 0);
    checkOutput("abort_max", int'(max8), 0);
    step();
    rst = 1'b0;
    step();
    runVec(vecs[2], "restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
